// File: rtl/uart_pkg.sv
// uart_pkg: shared arbiter state encoding and UART framing constants.
package uart_pkg;
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2,
      RELEASE   = 2'd3
   } arb_state_e;
   localparam int BAUD_VAL        = 87;
   localparam int UART_FRAME_BITS = 10;
   localparam int IDX_W           = 3;
endpackage

// File: rtl/uart_rr_picker.sv
// uart_rr_picker: combinational rotate-priority search starting just above ptr_i.
module uart_rr_picker
   import uart_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] req_valid_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic               pick_valid_o,
   output logic [IDX_W-1:0]   pick_idx_o
);
   logic [7:0]       req_v;
   logic [IDX_W-1:0] idx;
   always_comb begin
      req_v        = 8'(req_valid_i);
      idx          = '0;
      pick_valid_o = 1'b0;
      pick_idx_o   = '0;
      // Scan farthest offset first so the nearest requester above ptr_i wins.
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
         if (req_v[idx]) begin
            pick_valid_o = 1'b1;
            pick_idx_o   = idx;
         end
      end
   end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter between NUM_REQ byte sources.
// Define UART_ARB_TIMEOUT_EN to build the WAIT_DONE watchdog driving err_timeout_o.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [NUM_REQ-1:0]   req_valid_i,
   input  logic [8*NUM_REQ-1:0] req_data_i,
   output logic [NUM_REQ-1:0]   req_ready_o,
   output logic                 tx_data_valid_o,
   output logic [7:0]           tx_data_out_o,
   input  logic                 tx_active_i,
   input  logic                 tx_done_i,
   output logic [IDX_W-1:0]     grant_id_o,
   output logic                 busy_o,
   output logic [15:0]          sent_count_o,
   output logic                 err_timeout_o
);
   arb_state_e       state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d, grant_q, grant_d, pick_idx;
   logic [7:0]       data_q, data_d;
   logic [15:0]      sent_q, sent_d;
   logic             issue_q, pick_valid, tmo, unused_tx_active;

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES <= (UART_FRAME_BITS + 1) * BAUD_VAL) begin : g_bad_cfg
      $error("uart_tx_arbiter: NUM_REQ or TIMEOUT_CYCLES out of range");
   end

   uart_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .req_valid_i  (req_valid_i),
      .ptr_i        (ptr_q),
      .pick_valid_o (pick_valid),
      .pick_idx_o   (pick_idx)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      data_d  = data_q;
      sent_d  = sent_q;
      unique case (state_q)
         IDLE: if (pick_valid) begin
            state_d = ISSUE;
            ptr_d   = pick_idx;
            grant_d = pick_idx;
            data_d  = 8'(req_data_i >> {pick_idx, 3'b000});
         end
         ISSUE: state_d = WAIT_DONE;
         WAIT_DONE: if (tx_done_i) begin
            state_d = RELEASE;
            sent_d  = sent_q + 16'd1;
         end else if (tmo) state_d = IDLE;
         RELEASE: if (!tx_done_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         ptr_q   <= IDX_W'(NUM_REQ - 1);
         grant_q <= '0;
         data_q  <= '0;
         sent_q  <= '0;
         issue_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         data_q  <= data_d;
         sent_q  <= sent_d;
         issue_q <= state_d == ISSUE;
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] tmo_cnt_q;
   logic          err_q;
   // Counter idles at zero outside WAIT_DONE, so it is cleared on every entry.
   assign tmo = state_q == WAIT_DONE && !tx_done_i && tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1);
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tmo_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         tmo_cnt_q <= state_q == WAIT_DONE ? tmo_cnt_q + 1'b1 : '0;
         err_q     <= tmo;
      end
   end
   assign err_timeout_o = err_q;
`else
   assign tmo           = 1'b0;
   assign err_timeout_o = 1'b0;
`endif

   assign unused_tx_active = tx_active_i;
   assign req_ready_o      = {NUM_REQ{issue_q}} & (NUM_REQ'(1) << grant_q);
   assign tx_data_valid_o  = issue_q;
   assign tx_data_out_o    = data_q;
   assign grant_id_o       = grant_q;
   assign busy_o           = state_q != IDLE;
   assign sent_count_o     = sent_q;
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one `uart_transmitter` between `NUM_REQ` byte producers such as the command echo, status reporter and debug dump. Each requester offers one byte at a time. A round-robin scheduler picks one requester, hands the byte to the transmitter and waits for the full frame to complete before issuing the next byte. An optional watchdog recovers from a transmitter that never reports completion.

## Interface
- `NUM_REQ`, 4: number of requesters, range 2..8.
- `TIMEOUT_CYCLES`, 1024: watchdog limit in `clk` cycles. Must exceed 11×`BAUD_VAL`.
- `clk` in 1: system clock. All logic is rising-edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in `NUM_REQ`: requester i has a byte pending.
- `req_data` in `NUM_REQ`×8: byte of requester i at bits [8i+7:8i].
- `req_ready` out `NUM_REQ`: one-cycle accept pulse to the granted requester.
- `tx_data_valid` out 1: drives transmitter `data_valid`.
- `tx_data_out` out 8: drives transmitter `data_in`.
- `tx_active` in 1: from transmitter.
- `tx_done` in 1: from transmitter.
- `grant_id` out 3: index of the current or last granted requester.
- `busy` out 1: high in every state except IDLE.
- `sent_count` out 16: bytes completed. Wraps from 0xFFFF to 0.
- `err_timeout` out 1: one-cycle pulse when the watchdog fires.

## Operation
- Reset values of outputs and internal registers:
  - All outputs are 0.
  - Round-robin pointer = `NUM_REQ`-1, so requester 0 has highest priority first.
  - State = IDLE.
- IDLE:
  - If any `req_valid` is high, pick the first set bit searching upward from pointer+1, wrapping modulo `NUM_REQ`.
  - Register `tx_data_out` from the picked requester's byte, register `grant_id`, update pointer to the picked index, then go to ISSUE.
- ISSUE (exactly 1 cycle):
  - `tx_data_valid`=1 and `req_ready[grant_id]`=1.
  - Go to WAIT_DONE.
- WAIT_DONE:
  - Hold until `tx_done`=1.
  - Then increment `sent_count` and go to RELEASE.
- RELEASE:
  - Hold until `tx_done`=0, meaning the transmitter has returned to IDLE.
  - Then go to IDLE.
  - This guarantees the transmitter is idle whenever ISSUE is entered.
- `tx_active` is monitored only: `busy` reflects arbiter state. An ISSUE-to-WAIT_DONE transition with `tx_active` still 0 one cycle later is legal and not an error.
- Requesters must hold `req_data` stable while `req_valid`=1 until they see `req_ready`.
  - Deasserting `req_valid` before the grant is allowed.
  - A requester that deasserts after being picked in IDLE still receives its `req_ready` pulse, and the latched byte is sent.
- Simultaneous requests are resolved strictly by rotation. A continuously requesting source waits at most `NUM_REQ`-1 frames.
- Asynchronous reset mid-frame forces IDLE immediately. The transmitter is assumed to be reset by the same signal.

## Timing
- Latency from `req_valid` rising in IDLE to `tx_data_valid`: 1 cycle (the registered pick), so `tx_data_valid` is high in the 2nd cycle.
- Minimum spacing between successive `tx_data_valid` pulses = transmitter frame length + 3 cycles (RELEASE exit, IDLE pick, ISSUE).
- `req_ready` and `tx_data_valid` are always coincident, single-cycle and registered.
- `sent_count` updates on the edge leaving WAIT_DONE.

## Configuration
- With `UART_ARB_TIMEOUT_EN` defined:
  - A counter, cleared on entry to WAIT_DONE, counts cycles in WAIT_DONE.
  - On reaching `TIMEOUT_CYCLES` it pulses `err_timeout` for 1 cycle and goes directly to IDLE without incrementing `sent_count`.
  - `grant_id` keeps the failing index.
- Without the macro: no counter is built, WAIT_DONE waits indefinitely, and `err_timeout` is tied to 0.

## Structure
- Shared package `uart_pkg`:
  - State encodings IDLE/ISSUE/WAIT_DONE/RELEASE (2-bit).
  - `BAUD_VAL` default 87.
  - `UART_FRAME_BITS`=10.
- Sub-module `uart_rr_picker`: combinational rotate-priority search. Takes `req_valid` and the pointer; returns `pick_valid` and `pick_idx`.
- The arbiter FSM, data register and counters live in the top module.

## Test plan
All scenarios are paired with a real transmitter at `BAUD_VAL`=87.
- Single request: `req_valid`=0001, byte 0x55.
  - `tx_data_valid` pulses in cycle 2.
  - Serial line shows start bit, then 1,0,1,0,1,0,1,0, then stop bit.
  - `sent_count`=1.
- All four requesting continuously with bytes 0xA0..0xA3: grant order is 0,1,2,3,0; no requester is skipped.
- Request that arrives during a frame: requester 2 asserts while requester 0's byte is mid-frame.
  - Requester 2 is issued only after `tx_done` falls.
  - No `tx_data_valid` pulse occurs while `tx_active`=1.
- Async reset asserted during WAIT_DONE:
  - All outputs return to 0 immediately.
  - After release, the next grant goes to requester 0.
- `UART_ARB_TIMEOUT_EN` with `tx_done` forced to 0 and `TIMEOUT_CYCLES`=1024:
  - `err_timeout` pulses exactly 1024 cycles after entering WAIT_DONE.
  - The FSM returns to IDLE and `sent_count` is unchanged.
- `sent_count` preloaded to 0xFFFF via force: one completed byte → 0x0000.
